// File: rtl/cpu_data_port_responder.sv
// Memory-side responder for the CPU data port: one request at a time, fixed latency,
// serviced from a word RAM or a two-register MMIO window (timer, PWM).
module cpu_data_port_responder #(
  parameter int unsigned RAM_WORDS = 1024,
  parameter int unsigned LATENCY   = 2,
  parameter logic [31:0] MMIO_BASE = 32'h0001_0000,
  parameter logic [31:0] BAD_DATA  = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cpu_rw_addr,
  input  logic [1:0]  cpu_rw,
  inout  wire  [31:0] cpu_rw_data,
  output logic        cpu_rw_vld,
  input  logic [31:0] timer_data,
  output logic        timer_clr,
  output logic [31:0] pwm_data,
  output logic        addr_err
);

  localparam int unsigned IDX_W    = $clog2(RAM_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
  localparam logic [29:0] TIMER_WA = MMIO_BASE[31:2];
  localparam logic [29:0] PWM_WA   = MMIO_BASE[31:2] + 30'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_TURN
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [29:0] addr_q, addr_d;
  logic        rd_q, rd_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] pwm_q, pwm_d;

  logic [31:0] mem [RAM_WORDS];

  logic        hit_ram, hit_timer, hit_pwm;
  logic [31:0] rdata;
  logic        bus_oe;
  logic        ram_we;

  // Byte-lane bits are meaningless for word-only accesses.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_rw_addr[1:0];

  always_comb begin
    hit_ram   = addr_q < 30'(RAM_WORDS);
    hit_timer = addr_q == TIMER_WA;
    hit_pwm   = addr_q == PWM_WA;
    if (hit_ram)        rdata = mem[addr_q[IDX_W-1:0]];
    else if (hit_timer) rdata = timer_data;
    else if (hit_pwm)   rdata = pwm_q;
    else                rdata = BAD_DATA;
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    rd_d       = rd_q;
    wdata_d    = wdata_q;
    pwm_d      = pwm_q;
    cpu_rw_vld = 1'b0;
    timer_clr  = 1'b0;
    addr_err   = 1'b0;
    bus_oe     = 1'b0;
    ram_we     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cpu_rw[1]) begin
          addr_d  = cpu_rw_addr[31:2];
          rd_d    = cpu_rw[0];
          wdata_d = cpu_rw_data;
          cnt_d   = CNT_INIT;
          state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ST_RESP;
      end
      ST_RESP: begin
        cpu_rw_vld = 1'b1;
        addr_err   = !(hit_ram || hit_timer || hit_pwm);
        bus_oe     = rd_q;
        if (!rd_q) begin
          ram_we    = hit_ram;
          timer_clr = hit_timer;
          if (hit_pwm) pwm_d = wdata_q;
        end
        state_d = ST_TURN;
      end
      ST_TURN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wdata_q <= '0;
      pwm_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wdata_q <= wdata_d;
      pwm_q   <= pwm_d;
    end
  end

  // NOTE: the RAM array has no reset so it maps onto block/distributed RAM; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (rst_n && ram_we) mem[addr_q[IDX_W-1:0]] <= wdata_q;
  end

  assign pwm_data    = pwm_q;
  assign cpu_rw_data = bus_oe ? rdata : 'z;

endmodule
